// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller: feeds Y^block to an external GF(2^128) multiplier,
// folds in the length block, and publishes the final tag S with a multiplier timeout.
module ghash_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [127:0] iHashkey,
  input  logic [63:0]  iAad_len,
  input  logic [63:0]  iCtext_len,
  input  logic [127:0] iBlock,
  input  logic         iBlock_valid,
  input  logic         iBlock_last,
  output logic         oBlock_ready,
  output logic [127:0] oMul_ctext,
  output logic         oMul_ctext_valid,
  output logic [127:0] oMul_hashkey,
  output logic         oMul_hashkey_valid,
  input  logic [127:0] iMul_result,
  input  logic         iMul_result_valid,
  output logic [127:0] oTag,
  output logic         oTag_valid,
  output logic         oBusy,
  output logic         oError
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    MUL      = 3'd2,
    LEN      = 3'd3,
    LEN_MUL  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [127:0]     h_q, h_d;
  logic [127:0]     y_q, y_d;
  logic [127:0]     mul_ctext_q, mul_ctext_d;
  logic [127:0]     tag_q, tag_d;
  logic [63:0]      aad_len_q, aad_len_d;
  logic [63:0]      ctext_len_q, ctext_len_d;
  logic             mul_valid_q, mul_valid_d;
  logic             last_q, last_d;
  logic             tag_valid_q, tag_valid_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  // cnt_q is 0 on the first cycle in a multiply state, so TIMEOUT_CYCLES-1 marks the last allowed cycle
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      h_q         <= '0;
      y_q         <= '0;
      mul_ctext_q <= '0;
      tag_q       <= '0;
      aad_len_q   <= '0;
      ctext_len_q <= '0;
      mul_valid_q <= 1'b0;
      last_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      y_q         <= y_d;
      mul_ctext_q <= mul_ctext_d;
      tag_q       <= tag_d;
      aad_len_q   <= aad_len_d;
      ctext_len_q <= ctext_len_d;
      mul_valid_q <= mul_valid_d;
      last_q      <= last_d;
      tag_valid_q <= tag_valid_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    y_d         = y_q;
    mul_ctext_d = mul_ctext_q;
    tag_d       = tag_q;
    aad_len_d   = aad_len_q;
    ctext_len_d = ctext_len_q;
    mul_valid_d = mul_valid_q;
    last_d      = last_q;
    tag_valid_d = 1'b0;
    error_d     = error_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          h_d         = iHashkey;
          aad_len_d   = iAad_len;
          ctext_len_d = iCtext_len;
          y_d         = '0;
          error_d     = 1'b0;
          state_d     = ((iAad_len == '0) && (iCtext_len == '0)) ? LEN : WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        if (iBlock_valid) begin
          mul_ctext_d = y_q ^ iBlock;
          last_d      = iBlock_last;
          mul_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = MUL;
        end
      end
      MUL, LEN_MUL: begin
        if (iMul_result_valid) begin
          y_d         = iMul_result;
          mul_valid_d = 1'b0;
          if (state_q == LEN_MUL) begin
            state_d = DONE;
          end else begin
            state_d = last_q ? LEN : WAIT_BLK;
          end
        end else if (timeout) begin
          error_d     = 1'b1;
          mul_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LEN: begin
        mul_ctext_d = y_q ^ {aad_len_q, ctext_len_q};
        mul_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = LEN_MUL;
      end
      DONE: begin
        tag_d       = y_q;
        tag_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oBlock_ready       = (state_q == WAIT_BLK);
  assign oBusy              = (state_q != IDLE);
  assign oMul_ctext         = mul_ctext_q;
  assign oMul_ctext_valid   = mul_valid_q;
  assign oMul_hashkey       = h_q;
  assign oMul_hashkey_valid = mul_valid_q;
  assign oTag               = tag_q;
  assign oTag_valid         = tag_valid_q;
  assign oError             = error_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Bench for ghash_ctrl: multiplier stub with programmable latency, GHASH reference model,
// directed vectors plus randomized runs, timeout and mid-run reset scenarios.
module tb_ghash_ctrl;

  localparam logic [127:0] H_VEC   = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [127:0] C_VEC   = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [127:0] Y1_VEC  = 128'h5E2EC746917062882C85B0685353DEB7;
  localparam logic [127:0] TAG_VEC = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, blk_valid, blk_last;
  logic [127:0] hashkey, blk;
  logic [63:0]  aad, ct;
  logic         blk_ready, mul_v, mul_hk_v, tag_v, busy, err;
  logic [127:0] mul_ctext, mul_hk, tag;
  logic [127:0] mul_res;
  logic         mul_res_valid;

  ghash_ctrl dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iHashkey(hashkey),
    .iAad_len(aad), .iCtext_len(ct), .iBlock(blk), .iBlock_valid(blk_valid),
    .iBlock_last(blk_last), .oBlock_ready(blk_ready), .oMul_ctext(mul_ctext),
    .oMul_ctext_valid(mul_v), .oMul_hashkey(mul_hk), .oMul_hashkey_valid(mul_hk_v),
    .iMul_result(mul_res), .iMul_result_valid(mul_res_valid), .oTag(tag),
    .oTag_valid(tag_v), .oBusy(busy), .oError(err)
  );

  // Second instance whose multiplier never answers
  logic         t_start, t_ready, t_mulv, t_hkv, t_tagv, t_busy, t_err;
  logic [127:0] t_ctext, t_hk, t_tag;
  ghash_ctrl #(.TIMEOUT_CYCLES(8)) dut_to (
    .iClk(clk), .iRst(rst), .iStart(t_start), .iHashkey(H_VEC),
    .iAad_len(64'd0), .iCtext_len(64'd128), .iBlock(C_VEC), .iBlock_valid(1'b1),
    .iBlock_last(1'b1), .oBlock_ready(t_ready), .oMul_ctext(t_ctext),
    .oMul_ctext_valid(t_mulv), .oMul_hashkey(t_hk), .oMul_hashkey_valid(t_hkv),
    .iMul_result(128'd0), .iMul_result_valid(1'b0), .oTag(t_tag),
    .oTag_valid(t_tagv), .oBusy(t_busy), .oError(t_err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // GCM bit-reflected multiply in GF(2^128)
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 127; i >= 0; i--) begin
      if (x[i]) z ^= v;
      v = v[0] ? ((v >> 1) ^ {8'hE1, 120'd0}) : (v >> 1);
    end
    return z;
  endfunction

  logic [127:0] blks [8];

  function automatic logic [127:0] ghash_ref(input logic [127:0] h, input int n,
                                             input logic [63:0] a, input logic [63:0] c);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < n; i++) y = gf_mul(y ^ blks[i], h);
    return gf_mul(y ^ {a, c}, h);
  endfunction

  // Multiplier stub: answers each fresh valid request after lat cycles
  int           lat = 1;
  int           req_cnt = 0;
  int           scnt;
  logic         prev_v, pend;
  logic [127:0] pend_res, last_op;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_v        <= 1'b0;
      pend          <= 1'b0;
      scnt          <= 0;
      mul_res_valid <= 1'b0;
      mul_res       <= '0;
    end else begin
      prev_v        <= mul_v;
      mul_res_valid <= 1'b0;
      if (pend) begin
        if (scnt + 1 >= lat) begin
          mul_res_valid <= 1'b1;
          mul_res       <= pend_res;
          pend          <= 1'b0;
        end else begin
          scnt <= scnt + 1;
        end
      end else if (mul_v && mul_hk_v && !prev_v) begin
        req_cnt <= req_cnt + 1;
        last_op <= mul_ctext;
        if (lat <= 1) begin
          mul_res_valid <= 1'b1;
          mul_res       <= gf_mul(mul_ctext, mul_hk);
        end else begin
          pend     <= 1'b1;
          scnt     <= 1;
          pend_res <= gf_mul(mul_ctext, mul_hk);
        end
      end
    end
  end

  // One full run with iBlock_valid held high; noisy pulses iStart while busy
  task automatic run(input string name, input logic [127:0] h, input logic [63:0] a,
                     input logic [63:0] c, input int n, input int l, input bit noisy);
    int idx, pulses, cyc, req0;
    bit acc_prev, fin;
    logic [127:0] tag_seen, exp;
    lat = l;
    req0 = req_cnt;
    @(negedge clk);
    hashkey = h; aad = a; ct = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hashkey = {$urandom, $urandom, $urandom, $urandom};
    aad = {$urandom, $urandom};
    ct = {$urandom, $urandom};
    idx = 0; pulses = 0; cyc = 0; acc_prev = 1'b0; fin = 1'b0; tag_seen = '0;
    while (!fin && cyc < 3000) begin
      if (acc_prev) idx++;
      blk_valid = (idx < n);
      blk       = blks[(idx < 8) ? idx : 0];
      blk_last  = (idx == n - 1);
      start     = noisy && busy && ($urandom_range(1, 0) == 1);
      acc_prev  = blk_ready && blk_valid;
      @(negedge clk);
      cyc++;
      if (tag_v) begin
        pulses++;
        tag_seen = tag;
      end
      if ((pulses > 0 && !tag_v) || err) fin = 1'b1;
    end
    if (acc_prev) idx++;
    start = 1'b0;
    blk_valid = 1'b0;
    exp = ghash_ref(h, n, a, c);
    chk({name, "_finished"}, 128'(fin), 128'd1);
    chk({name, "_tag"}, tag_seen, exp);
    chk({name, "_pulses"}, 128'(pulses), 128'd1);
    chk({name, "_accepted"}, 128'(idx), 128'(n));
    chk({name, "_mul_requests"}, 128'(req_cnt - req0), 128'(n + 1));
    chk({name, "_error"}, 128'(err), 128'd0);
    repeat (3) @(negedge clk);
    chk({name, "_tag_hold"}, tag, exp);
    $display("run %s: blocks=%0d lat=%0d cycles=%0d tag=%h", name, n, l, cyc, tag_seen);
  endtask

  initial begin
    int cyc, mulcyc, tv;
    rst = 1'b1; start = 1'b0; t_start = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;
    hashkey = '0; aad = '0; ct = '0; blk = '0;
    repeat (3) @(negedge clk);
    chk("rst_tag", tag, 128'd0);
    chk("rst_tag_valid", 128'(tag_v), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_error", 128'(err), 128'd0);
    chk("rst_ready", 128'(blk_ready), 128'd0);
    chk("rst_mul_valid", 128'(mul_v), 128'd0);
    chk("rst_mul_ctext", mul_ctext, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'd0);

    run("zero_len", H_VEC, 64'd0, 64'd0, 0, 3, 1'b0);
    chk("zero_len_tag_is_zero", tag, 128'd0);

    blks[0] = C_VEC;
    run("vec_one_block", H_VEC, 64'd0, 64'd128, 1, 4, 1'b0);
    chk("vec_y_after_block", last_op ^ {64'd0, 64'd128}, Y1_VEC);
    chk("vec_tag", tag, TAG_VEC);

    for (int i = 0; i < 8; i++) blks[i] = {$urandom, $urandom, $urandom, $urandom};
    run("held_lat1", {$urandom, $urandom, $urandom, $urandom}, 64'd256, 64'd512, 4, 1, 1'b0);
    run("held_lat10", {$urandom, $urandom, $urandom, $urandom}, 64'd128, 64'd384, 4, 10, 1'b0);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) blks[i] = {$urandom, $urandom, $urandom, $urandom};
      run($sformatf("rand%0d", r), {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom | 32'd1}, {$urandom, $urandom},
          int'($urandom_range(6, 1)), int'($urandom_range(12, 1)), 1'b1);
    end

    // Timeout instance: result never arrives
    @(negedge clk); t_start = 1'b1;
    @(negedge clk); t_start = 1'b0;
    cyc = 0; mulcyc = 0; tv = 0;
    while (!t_err && cyc < 100) begin
      if (t_mulv) mulcyc++;
      if (t_tagv) tv++;
      @(negedge clk);
      cyc++;
    end
    chk("to_error", 128'(t_err), 128'd1);
    chk("to_cycles_in_mul", 128'(mulcyc), 128'd8);
    chk("to_idle", 128'(t_busy), 128'd0);
    chk("to_mul_valid_dropped", 128'(t_mulv), 128'd0);
    chk("to_no_tag_pulse", 128'(tv + 32'(t_tagv)), 128'd0);
    @(negedge clk);
    chk("to_error_sticky", 128'(t_err), 128'd1);
    t_start = 1'b1;
    @(negedge clk); t_start = 1'b0;
    chk("to_error_cleared_on_start", 128'(t_err), 128'd0);
    $display("timeout: cycles_in_mul=%0d", mulcyc);

    // Reset in the middle of a 2-block run
    lat = 10;
    blks[0] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    hashkey = H_VEC; aad = 64'd0; ct = 64'd256; start = 1'b1;
    @(negedge clk);
    start = 1'b0; blk = blks[0]; blk_valid = 1'b1; blk_last = 1'b0;
    cyc = 0;
    while (!mul_v && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    blk_valid = 1'b0;
    chk("mid_reached_mul", 128'(mul_v), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_mul_valid", 128'(mul_v), 128'd0);
    chk("mid_rst_mul_ctext", mul_ctext, 128'd0);
    chk("mid_rst_tag", tag, 128'd0);
    chk("mid_rst_tag_valid", 128'(tag_v), 128'd0);
    chk("mid_rst_ready", 128'(blk_ready), 128'd0);
    chk("mid_rst_error", 128'(err), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    blks[0] = C_VEC;
    run("after_reset", H_VEC, 64'd0, 64'd128, 1, 2, 1'b1);
    chk("after_reset_vec_tag", tag, TAG_VEC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ghash_ctrl.md
GHASH_CTRL -- requirements
Module: ghash_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for a multiplier result before flagging an error.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 iClk  input  1  system clock; all state changes on the rising edge.
REQ-004 iRst  input  1  asynchronous active-high reset.
REQ-005 iStart  input  1  start a new GHASH computation; honoured only in IDLE.
REQ-006 iHashkey  input  128  hash subkey H; latched on an accepted iStart.
REQ-007 iAad_len  input  64  AAD length in bits; latched on an accepted iStart.
REQ-008 iCtext_len  input  64  ciphertext length in bits; latched on an accepted iStart.
REQ-009 iBlock  input  128  padded AAD or ciphertext block, MSB = first byte.
REQ-010 iBlock_valid  input  1  iBlock is valid.
REQ-011 iBlock_last  input  1  qualifies iBlock as the final data block.
REQ-012 oBlock_ready  output  1  controller accepts iBlock this cycle.
REQ-013 oMul_ctext  output  128  multiplier operand (Y xor block).
REQ-014 oMul_ctext_valid  output  1  operand valid, level, to the gfmul_v2 iCtext_valid input.
REQ-015 oMul_hashkey  output  128  latched H, driven to gfmul_v2 iHashkey.
REQ-016 oMul_hashkey_valid  output  1  high whenever oMul_ctext_valid is high.
REQ-017 iMul_result  input  128  gfmul_v2 oResult.
REQ-018 iMul_result_valid  input  1  gfmul_v2 oResult_valid.
REQ-019 oTag  output  128  final GHASH value S.
REQ-020 oTag_valid  output  1  one-cycle pulse when oTag is updated.
REQ-021 oBusy  output  1  high in every state except IDLE.
REQ-022 oError  output  1  sticky multiplier-timeout flag.

Function
REQ-023 State machine SHALL have the states IDLE, WAIT_BLK, MUL, LEN, LEN_MUL and DONE.
REQ-024 IDLE: an iStart SHALL latch H and both lengths, clear Y to 0 and oError, then go to WAIT_BLK; if iAad_len and iCtext_len are both 0, go to LEN instead.
REQ-025 WAIT_BLK: oBlock_ready=1; a block is accepted when iBlock_valid and oBlock_ready are both high.
REQ-026 On an accepted block, the controller SHALL register oMul_ctext = Y ^ iBlock, register last_flag = iBlock_last, and go to MUL.
REQ-027 MUL and LEN_MUL: oMul_ctext_valid and oMul_hashkey_valid SHALL stay high until the first cycle in which iMul_result_valid is sampled high.
REQ-028 On that first cycle, the controller SHALL set Y = iMul_result and drop both valids to 0 in the next cycle.
REQ-029 Valids SHALL stay low for at least 1 cycle between multiplications, so the multiplier sees a fresh request.
REQ-030 After MUL, the next state SHALL be LEN if last_flag=1, otherwise WAIT_BLK.
REQ-031 LEN: the controller SHALL register oMul_ctext = Y ^ {aad_len[63:0], ctext_len[63:0]} and go to LEN_MUL; oBlock_ready=0.
REQ-032 After LEN_MUL the next state SHALL be DONE; DONE SHALL set oTag = Y and pulse oTag_valid for 1 cycle, then go to IDLE.
REQ-033 oTag SHALL hold its value until the next DONE.
REQ-034 Latency per block SHALL be 1 (accept) + multiplier latency + 1 (capture) cycles; the length block adds the same again, plus 1 cycle for DONE.
REQ-035 A timeout counter SHALL count cycles spent in MUL or LEN_MUL and reset on entry to either state.
REQ-036 If the timeout counter reaches TIMEOUT_CYCLES, the controller SHALL set oError=1, drop the multiplier valids, skip the oTag_valid pulse and return to IDLE.
REQ-037 iStart outside IDLE SHALL be ignored; iBlock_valid outside WAIT_BLK SHALL be ignored and the block SHALL NOT be consumed.
REQ-038 iBlock_last with zero declared lengths is a don't-care; the length block SHALL always be processed exactly once per run.
REQ-039 No XOR is applied to iMul_result; it SHALL be stored verbatim into Y.

Reset
REQ-040 iRst=1 SHALL asynchronously force the state to IDLE and clear Y, oMul_ctext, oTag, all valids, oBlock_ready, oBusy, oError and the counter to 0.
REQ-041 Reset asserted mid-operation SHALL abort the run with no oTag_valid pulse; the first iStart after deassertion starts a clean run.

Verification
REQ-042 Lengths 0/0, H=66E94BD4EF8A2C3B884CFA59CA342B2E, no blocks -> one length multiplication of 0, oTag=0, oTag_valid pulses once.
REQ-043 Same H, iCtext_len=128, single block 0388DACE60B6A392F328C2B971B2FE78 with last -> Y after the block = 5E2EC746917062882C85B0685353DEB7, oTag = F38CBB1AD69223DCC3457AE5B6B0F885.
REQ-044 iBlock_valid held high, with the multiplier returning after 1 cycle and after 10 cycles -> each block accepted exactly once, valids drop for at least 1 cycle between requests.
REQ-045 Multiplier stub never asserts result valid, TIMEOUT_CYCLES=8 -> oError=1 after 8 cycles in MUL, state IDLE, no oTag_valid.
REQ-046 iRst pulsed while in MUL of a 2-block run -> all outputs 0 immediately; a following run with the vector from REQ-043 gives the same oTag.
REQ-047 iStart pulsed while oBusy=1 -> no effect on Y, the latched lengths or oTag.
